// File: rtl/ca_project.sv
// Five-stage RV32I-subset pipeline (ADD/SUB/AND/OR/ADDI/LW/SW/BEQ) with internal ROM,
// data RAM, full EX forwarding, one-cycle load-use stall and EX-resolved branches.
module ca_project (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Out_value
);

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

  // ---------------------------------------------------------------- IF
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_instr;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    case (pc[6:2])
      5'd0:    if_instr = 32'h00500093;  // addi x1,x0,5
      5'd1:    if_instr = 32'h00A00113;  // addi x2,x0,10
      5'd2:    if_instr = 32'h002081B3;  // add  x3,x1,x2
      5'd3:    if_instr = 32'h40110233;  // sub  x4,x2,x1
      5'd4:    if_instr = 32'h00302023;  // sw   x3,0(x0)
      5'd5:    if_instr = 32'h00002283;  // lw   x5,0(x0)
      5'd6:    if_instr = 32'h00128333;  // add  x6,x5,x1
      5'd7:    if_instr = 32'h00120663;  // beq  x4,x1,+12
      5'd8:    if_instr = 32'h00100393;  // addi x7,x0,1
      5'd9:    if_instr = 32'h00200393;  // addi x7,x0,2
      5'd10:   if_instr = 32'h0020E433;  // or   x8,x1,x2
      5'd11:   if_instr = 32'h0041F4B3;  // and  x9,x3,x4
      5'd12:   if_instr = 32'h00000063;  // beq  x0,x0,0
      default: if_instr = INSTR_NOP;
    endcase
  end

  // ---------------------------------------------------------------- pipeline registers
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  logic [31:0] idex_pc;
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
  logic [4:0]  idex_rd;
  logic [31:0] idex_rs1_val;
  logic [31:0] idex_rs2_val;
  logic [31:0] idex_imm;
  alu_op_t     idex_alu_op;
  logic        idex_alu_imm;
  logic        idex_mem_read;
  logic        idex_mem_write;
  logic        idex_reg_write;
  logic        idex_branch;

  logic [31:0] exmem_alu_res;
  logic [31:0] exmem_store;
  logic [4:0]  exmem_rd;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic        exmem_reg_write;

  logic [31:0] memwb_data;
  logic [4:0]  memwb_rd;
  logic        memwb_reg_write;

  // ---------------------------------------------------------------- ID
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;

  assign id_opcode = ifid_instr[6:0];
  assign id_funct3 = ifid_instr[14:12];
  assign id_funct7 = ifid_instr[31:25];
  assign id_rs1    = ifid_instr[19:15];
  assign id_rs2    = ifid_instr[24:20];
  assign id_rd     = ifid_instr[11:7];

  logic [31:0] id_imm;
  alu_op_t     id_alu_op;
  logic        id_alu_imm;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_branch;
  logic        id_use_rs1;
  logic        id_use_rs2;

  // Unsupported encodings fall through with every control deasserted, i.e. a NOP.
  always_comb begin
    id_imm       = '0;
    id_alu_op    = ALU_ADD;
    id_alu_imm   = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    id_reg_write = 1'b0;
    id_branch    = 1'b0;
    id_use_rs1   = 1'b0;
    id_use_rs2   = 1'b0;
    case (id_opcode)
      7'b0110011: begin
        if (id_funct3 == 3'b000 && id_funct7 == 7'b0000000) begin
          id_alu_op    = ALU_ADD;
          id_reg_write = 1'b1;
        end else if (id_funct3 == 3'b000 && id_funct7 == 7'b0100000) begin
          id_alu_op    = ALU_SUB;
          id_reg_write = 1'b1;
        end else if (id_funct3 == 3'b111 && id_funct7 == 7'b0000000) begin
          id_alu_op    = ALU_AND;
          id_reg_write = 1'b1;
        end else if (id_funct3 == 3'b110 && id_funct7 == 7'b0000000) begin
          id_alu_op    = ALU_OR;
          id_reg_write = 1'b1;
        end
        id_use_rs1 = id_reg_write;
        id_use_rs2 = id_reg_write;
      end
      7'b0010011: begin
        if (id_funct3 == 3'b000) begin
          id_imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
          id_alu_imm   = 1'b1;
          id_reg_write = 1'b1;
          id_use_rs1   = 1'b1;
        end
      end
      7'b0000011: begin
        if (id_funct3 == 3'b010) begin
          id_imm       = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
          id_alu_imm   = 1'b1;
          id_mem_read  = 1'b1;
          id_reg_write = 1'b1;
          id_use_rs1   = 1'b1;
        end
      end
      7'b0100011: begin
        if (id_funct3 == 3'b010) begin
          id_imm       = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
          id_alu_imm   = 1'b1;
          id_mem_write = 1'b1;
          id_use_rs1   = 1'b1;
          id_use_rs2   = 1'b1;
        end
      end
      7'b1100011: begin
        if (id_funct3 == 3'b000) begin
          id_imm     = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                        ifid_instr[30:25], ifid_instr[11:8], 1'b0};
          id_branch  = 1'b1;
          id_use_rs1 = 1'b1;
          id_use_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- register file
  logic [31:0] rf [32];
  logic        wb_we;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;

  assign wb_we = memwb_reg_write && (memwb_rd != 5'd0);

  // Same-cycle WB write is bypassed into the ID read.
  assign id_rs1_val = (wb_we && memwb_rd == id_rs1) ? memwb_data : rf[id_rs1];
  assign id_rs2_val = (wb_we && memwb_rd == id_rs2) ? memwb_data : rf[id_rs2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[memwb_rd] <= memwb_data;
    end
  end

  // ---------------------------------------------------------------- hazards
  logic load_use;

  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((id_use_rs1 && idex_rd == id_rs1) ||
                     (id_use_rs2 && idex_rd == id_rs2));

  // ---------------------------------------------------------------- EX
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic [31:0] ex_alu_b;
  logic [31:0] ex_alu_res;
  logic        ex_taken;
  logic [31:0] ex_target;

  always_comb begin
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)
      ex_op_a = exmem_alu_res;
    else if (wb_we && memwb_rd == idex_rs1)
      ex_op_a = memwb_data;
    else
      ex_op_a = idex_rs1_val;

    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)
      ex_op_b = exmem_alu_res;
    else if (wb_we && memwb_rd == idex_rs2)
      ex_op_b = memwb_data;
    else
      ex_op_b = idex_rs2_val;
  end

  assign ex_alu_b = idex_alu_imm ? idex_imm : ex_op_b;

  always_comb begin
    case (idex_alu_op)
      ALU_SUB: ex_alu_res = ex_op_a - ex_alu_b;
      ALU_AND: ex_alu_res = ex_op_a & ex_alu_b;
      ALU_OR:  ex_alu_res = ex_op_a | ex_alu_b;
      default: ex_alu_res = ex_op_a + ex_alu_b;
    endcase
  end

  assign ex_taken  = idex_branch && (ex_op_a == ex_op_b);
  assign ex_target = idex_pc + idex_imm;

  // ---------------------------------------------------------------- MEM
  logic [31:0] dmem [32];
  logic [31:0] mem_rdata;
  logic [31:0] mem_wb_data;

  assign mem_rdata   = dmem[exmem_alu_res[6:2]];
  assign mem_wb_data = exmem_mem_read ? mem_rdata : exmem_alu_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) dmem[i] <= '0;
    end else if (exmem_mem_write) begin
      dmem[exmem_alu_res[6:2]] <= exmem_store;
    end
  end

  // ---------------------------------------------------------------- pipeline state
  // A taken branch outranks the load-use stall; both cannot coexist since the
  // stall needs a load, not a branch, in EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc              <= '0;
      ifid_pc         <= '0;
      ifid_instr      <= '0;
      idex_pc         <= '0;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      idex_rd         <= '0;
      idex_rs1_val    <= '0;
      idex_rs2_val    <= '0;
      idex_imm        <= '0;
      idex_alu_op     <= ALU_ADD;
      idex_alu_imm    <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_branch     <= 1'b0;
      exmem_alu_res   <= '0;
      exmem_store     <= '0;
      exmem_rd        <= '0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_reg_write <= 1'b0;
      memwb_data      <= '0;
      memwb_rd        <= '0;
      memwb_reg_write <= 1'b0;
      Out_value       <= '0;
    end else begin
      if (ex_taken) begin
        pc         <= ex_target;
        ifid_pc    <= '0;
        ifid_instr <= '0;
      end else if (!load_use) begin
        pc         <= pc_plus4;
        ifid_pc    <= pc;
        ifid_instr <= if_instr;
      end

      if (ex_taken || load_use) begin
        idex_pc        <= '0;
        idex_rs1       <= '0;
        idex_rs2       <= '0;
        idex_rd        <= '0;
        idex_rs1_val   <= '0;
        idex_rs2_val   <= '0;
        idex_imm       <= '0;
        idex_alu_op    <= ALU_ADD;
        idex_alu_imm   <= 1'b0;
        idex_mem_read  <= 1'b0;
        idex_mem_write <= 1'b0;
        idex_reg_write <= 1'b0;
        idex_branch    <= 1'b0;
      end else begin
        idex_pc        <= ifid_pc;
        idex_rs1       <= id_rs1;
        idex_rs2       <= id_rs2;
        idex_rd        <= id_rd;
        idex_rs1_val   <= id_rs1_val;
        idex_rs2_val   <= id_rs2_val;
        idex_imm       <= id_imm;
        idex_alu_op    <= id_alu_op;
        idex_alu_imm   <= id_alu_imm;
        idex_mem_read  <= id_mem_read;
        idex_mem_write <= id_mem_write;
        idex_reg_write <= id_reg_write;
        idex_branch    <= id_branch;
      end

      exmem_alu_res   <= ex_alu_res;
      exmem_store     <= ex_op_b;
      exmem_rd        <= idex_rd;
      exmem_mem_read  <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;
      exmem_reg_write <= idex_reg_write;

      memwb_data      <= mem_wb_data;
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;

      if (wb_we) Out_value <= memwb_data;
    end
  end

endmodule

// File: tb/tb_ca_project.sv
// Scoreboard bench for ca_project: per-edge Out_value expectations are queued by the
// stimulus process and consumed by an independent monitor after each rising edge.
module tb_ca_project;

  logic        clk   = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] Out_value;

  ca_project dut (
    .clk       (clk),
    .reset     (reset),
    .Out_value (Out_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          ecnt  = 0;
  logic [31:0] out_tab [1:20];
  logic [31:0] reg_tab [1:9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic push_expect(input int last_edge);
    for (int e = 1; e <= last_edge; e++) begin
      exp_t x;
      x.edge_no = e;
      x.val     = out_tab[e];
      exp_q.push_back(x);
    end
  endtask

  task automatic check_final(input string tag);
    for (int r = 1; r <= 9; r++)
      check($sformatf("%s_x%0d", tag, r), dut.rf[r], reg_tab[r]);
    check({tag, "_dmem0"}, dut.dmem[0], 32'd15);
  endtask

  // Monitor: counts edges since reset release and compares due expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        ecnt = 0;
      end else begin
        ecnt++;
        while (exp_q.size() > 0 && exp_q[0].edge_no <= ecnt) begin
          exp_t x;
          x = exp_q.pop_front();
          check($sformatf("out_edge%0d", x.edge_no), Out_value, x.val);
        end
      end
    end
  end

  initial begin
    out_tab = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd10, 32'd15, 32'd5, 32'd5, 32'd15,
                32'd15, 32'd20, 32'd20, 32'd20, 32'd20, 32'd15, 32'd5, 32'd5, 32'd5, 32'd5};
    reg_tab = '{32'd5, 32'd10, 32'd15, 32'd5, 32'd15, 32'd20, 32'd0, 32'd15, 32'd5};

    // Reset held for 1.5 cycles, released mid-cycle.
    #12;
    check("rst_out", Out_value, 32'd0);
    check("rst_x1", dut.rf[1], 32'd0);
    check("rst_dmem0", dut.dmem[0], 32'd0);
    push_expect(20);
    #3;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("drain_run1", exp_q.size(), 32'd0);
    check_final("run1");

    // Reset during the self-loop clears everything asynchronously.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst2_out", Out_value, 32'd0);
    check("rst2_dmem0", dut.dmem[0], 32'd0);
    check("rst2_x3", dut.rf[3], 32'd0);

    // Restart, then abort just before edge 10 (store has landed, load not retired).
    @(negedge clk);
    push_expect(9);
    reset = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    check("drain_run2", exp_q.size(), 32'd0);
    check("pre_abort_dmem0", dut.dmem[0], 32'd15);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_out", Out_value, 32'd0);
    check("abort_dmem0", dut.dmem[0], 32'd0);
    check("abort_x4", dut.rf[4], 32'd0);

    // Program repeats fully from address 0.
    repeat (2) @(negedge clk);
    push_expect(20);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("drain_run3", exp_q.size(), 32'd0);
    check_final("run3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
